sar_avg_fifo: RTL and testbench
===============================

Name: sar_avg_fifo

Overview:
- Downstream consumer of the 8-bit SAR ADC conversion stage.
- Captures each completed conversion (`digital_out` qualified by `out_flag`) and averages blocks of 2^LOG2_AVG samples.
- Decimated averages go into a small FIFO, read out through a valid/ready handshake toward the system/readout logic.

Parameters:
- DATA_W, 8, width of the ADC result and of the averaged output.
- LOG2_AVG, 2, log2 of the samples per average block (4 by default); legal range 0..4.
- FIFO_DEPTH, 4, number of average entries held; must be a power of two, 2..16.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  averaging enable; low = accumulator held cleared.
- out_flag  input  1  conversion-done flag from the SAR stage; may stay high several cycles.
- digital_out  input  DATA_W  conversion result, stable while out_flag is high.
- avg_data  output  DATA_W  FIFO head (oldest average).
- avg_valid  output  1  FIFO non-empty.
- avg_ready  input  1  consumer accepts avg_data this cycle.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  number of entries held.
- overflow  output  1  sticky; set when an average is dropped because the FIFO was full.
- sample_cnt  output  LOG2_AVG+1  samples accumulated in the current block.

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0: avg_data, avg_valid, fifo_level, overflow, sample_cnt.
  - flag_d=0, acc=0, FIFO pointers=0, FSM=IDLE.
  - rst asserted mid-block or with a non-empty FIFO discards everything; there is no partial-average output.
- Edge detect:
  - flag_d is registered out_flag every cycle.
  - cap = out_flag & ~flag_d & (state==ACCUM).
  - One capture per out_flag rising edge, however long the flag is held.
- FSM:
  - IDLE: acc=0, sample_cnt=0. Moves to ACCUM on the first clock edge with enable=1. A rising edge of out_flag on that same cycle is ignored.
  - ACCUM: a clock edge with enable=0 returns to IDLE and clears acc and sample_cnt; any pending capture on that edge is ignored. The FIFO keeps its contents and keeps draining.
- Accumulation:
  - acc width is DATA_W+LOG2_AVG, unsigned; it cannot overflow.
  - On cap with sample_cnt < 2^LOG2_AVG-1: acc += digital_out; sample_cnt++.
  - On cap with sample_cnt == 2^LOG2_AVG-1 (the block completes):
    - push = 1, with push data = (acc + digital_out) >> LOG2_AVG (truncation, no rounding).
    - acc and sample_cnt are cleared on the same edge.
  - LOG2_AVG=0: every capture pushes digital_out unchanged.
- Latency:
  - With an empty FIFO, avg_valid=1 and avg_data are valid immediately after the clock edge on which cap for the final sample is true.
  - That is 1 clk after out_flag rises as seen at the flop input.
- FIFO:
  - Synchronous, first-word-fall-through; avg_data = mem[rd_ptr].
  - pop = avg_valid & avg_ready.
  - Push when not full: written at wr_ptr, which then advances.
  - Push when full and no pop: data dropped, overflow set to 1 (sticky until rst), FIFO unchanged.
  - Push and pop on the same edge:
    - full: both happen, level unchanged, no overflow.
    - empty: impossible, because pop requires valid.
    - otherwise: level unchanged.
  - avg_ready while empty has no effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level is in the range 0..FIFO_DEPTH.
- avg_data is undefined-but-stable (the last mem value) while avg_valid=0. The bench checks it only when valid.

Test Plan:
1. Basic average:
   - Stimulus: rst pulse, enable=1, four conversions 10, 11, 12, 13 (each out_flag high 2 clk, 8 clk apart).
   - Required: after the 4th edge, avg_valid=1, avg_data=11 (46>>2), fifo_level=1.
   - Then avg_ready=1 for 1 clk gives avg_valid=0, fifo_level=0.
2. Full-scale:
   - Stimulus: four samples of 255.
   - Required: avg_data=255 (acc=1020, no wrap).
   - Then four samples of 0, 0, 0, 3: avg_data=0 (3>>2 truncates).
3. Held flag:
   - Stimulus: out_flag held high 10 clk with digital_out=50.
   - Required: sample_cnt increments by exactly 1.
   - Four such pulses give avg_data=50.
4. FIFO full/overflow:
   - Stimulus: avg_ready=0, produce 5 averages (values 1..5).
   - Required: fifo_level=4, overflow=1 after the 5th.
   - Draining yields 1, 2, 3, 4 in order.
   - A simultaneous push+pop at full keeps fifo_level=4 with overflow unchanged.
5. Enable drop mid-block:
   - Stimulus: 2 samples of 100, enable=0 for 3 clk, enable=1, then 4 samples of 8.
   - Required: single output avg_data=8; sample_cnt=0 while disabled.
   - FIFO contents from earlier blocks are retained.
6. Reset mid-operation:
   - Stimulus: with 2 entries queued and sample_cnt=3, assert rst asynchronously (between clock edges).
   - Required: all outputs drop to 0 immediately without a clock edge.
   - After release, the next 4 samples produce exactly one fresh average.

Source files
------------

// File: rtl/sar_avg_fifo.sv
// Block averager for SAR ADC conversions, with a first-word-fall-through FIFO
// on the output side that holds the decimated averages.
module sar_avg_fifo #(
   parameter int DATA_W     = 8,
   parameter int LOG2_AVG   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            enable,
   input  logic                            out_flag,
   input  logic [DATA_W-1:0]               digital_out,
   output logic [DATA_W-1:0]               avg_data,
   output logic                            avg_valid,
   input  logic                            avg_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            overflow,
   output logic [LOG2_AVG:0]               sample_cnt
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ACC_W = DATA_W + LOG2_AVG;
   localparam int CNT_W = LOG2_AVG + 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_AVG) - 1);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t             state;
   logic               flag_d;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   sum;
   logic               cap;
   logic               cap_en;
   logic               block_done;
   logic               push;
   logic [DATA_W-1:0]  push_data;

   logic [DATA_W-1:0]  mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   rd_ptr;
   logic [PTR_W-1:0]   wr_ptr;
   logic [LVL_W-1:0]   level;
   logic               full;
   logic               pop;
   logic               wr_en;

   // A capture on the same edge that enable drops is discarded with the block.
   assign cap        = out_flag & ~flag_d & (state == ACCUM);
   assign cap_en     = cap & enable;
   assign block_done = (sample_cnt == LAST_CNT);
   assign sum        = acc + ACC_W'(digital_out);
   assign push       = cap_en & block_done;
   assign push_data  = DATA_W'(sum >> LOG2_AVG);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         flag_d     <= 1'b0;
         acc        <= '0;
         sample_cnt <= '0;
      end else begin
         flag_d <= out_flag;
         case (state)
            IDLE: begin
               acc        <= '0;
               sample_cnt <= '0;
               if (enable) state <= ACCUM;
            end
            ACCUM: begin
               if (!enable) begin
                  state      <= IDLE;
                  acc        <= '0;
                  sample_cnt <= '0;
               end else if (cap) begin
                  if (block_done) begin
                     acc        <= '0;
                     sample_cnt <= '0;
                  end else begin
                     acc        <= sum;
                     sample_cnt <= sample_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign full      = (level == LVL_W'(FIFO_DEPTH));
   assign avg_valid = (level != '0);
   assign pop       = avg_valid & avg_ready;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign wr_en     = push & (~full | pop);

   assign avg_data   = mem[rd_ptr];
   assign fifo_level = level;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         if (wr_en && !pop)      level <= level + LVL_W'(1);
         else if (!wr_en && pop) level <= level - LVL_W'(1);
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sar_avg_fifo.sv
// Scoreboard bench for sar_avg_fifo: expected averages are queued as blocks are
// issued, and a monitor compares every FIFO pop against the queue head.
module tb_sar_avg_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       out_flag;
   logic [7:0] digital_out;
   logic [7:0] avg_data;
   logic       avg_valid;
   logic       avg_ready;
   logic [2:0] fifo_level;
   logic       overflow;
   logic [2:0] sample_cnt;

   int checks   = 0;
   int failures = 0;
   logic [7:0] sb [$];

   sar_avg_fifo #(.DATA_W(8), .LOG2_AVG(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable), .out_flag(out_flag),
      .digital_out(digital_out), .avg_data(avg_data), .avg_valid(avg_valid),
      .avg_ready(avg_ready), .fifo_level(fifo_level), .overflow(overflow),
      .sample_cnt(sample_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Monitor: every accepted output must match the oldest expected average.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && avg_valid && avg_ready) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_pop", 32'(avg_data), 32'hFFFF_FFFF);
            end else begin
               checkOutput("sb_avg_data", 32'(avg_data), 32'(sb.pop_front()));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One conversion: flag high for 'hold' cycles, then low for 'gap' cycles.
   task automatic applyStimulus(input logic [7:0] v, input int hold = 2,
                                input int gap = 6, input bit pop_at_cap = 1'b0);
      tick();
      digital_out = v;
      out_flag    = 1'b1;
      if (pop_at_cap) avg_ready = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (pop_at_cap) avg_ready = 1'b0;
      end
      out_flag = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic block4(input logic [7:0] v, input bit expect_push = 1'b1);
      if (expect_push) sb.push_back(v);
      for (int i = 0; i < 4; i++) applyStimulus(v);
   endtask

   task automatic drain(input int n);
      tick();
      avg_ready = 1'b1;
      repeat (n) tick();
      avg_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; out_flag = 1'b0; digital_out = '0; avg_ready = 1'b0;
      #12;
      checkOutput("rst_avg_data",   32'(avg_data),   0);
      checkOutput("rst_avg_valid",  32'(avg_valid),  0);
      checkOutput("rst_fifo_level", 32'(fifo_level), 0);
      checkOutput("rst_overflow",   32'(overflow),   0);
      checkOutput("rst_sample_cnt", 32'(sample_cnt), 0);
      tick();
      rst = 1'b0;
      enable = 1'b1;

      // Basic average: (10+11+12+13)>>2 = 11
      applyStimulus(8'd10); applyStimulus(8'd11); applyStimulus(8'd12);
      checkOutput("t1_sample_cnt", 32'(sample_cnt), 3);
      sb.push_back(8'd11);
      applyStimulus(8'd13);
      checkOutput("t1_avg_valid",  32'(avg_valid),  1);
      checkOutput("t1_avg_data",   32'(avg_data),   11);
      checkOutput("t1_fifo_level", 32'(fifo_level), 1);
      drain(1);
      checkOutput("t1_valid_after_pop", 32'(avg_valid),  0);
      checkOutput("t1_level_after_pop", 32'(fifo_level), 0);

      // Full scale, then truncation of 3>>2
      block4(8'd255);
      checkOutput("t2_full_scale", 32'(avg_data), 255);
      drain(1);
      applyStimulus(8'd0); applyStimulus(8'd0); applyStimulus(8'd0);
      sb.push_back(8'd0);
      applyStimulus(8'd3);
      checkOutput("t2_trunc", 32'(avg_data), 0);
      drain(1);

      // Held flag counts once per rising edge
      applyStimulus(8'd50, 10);
      checkOutput("t3_held_cnt", 32'(sample_cnt), 1);
      sb.push_back(8'd50);
      for (int i = 0; i < 3; i++) applyStimulus(8'd50, 10);
      checkOutput("t3_held_avg", 32'(avg_data), 50);
      drain(1);

      // FIFO full and overflow
      for (int v = 1; v <= 5; v++) block4(8'(v), v <= 4);
      checkOutput("t4_level_full", 32'(fifo_level), 4);
      checkOutput("t4_overflow",   32'(overflow),   1);
      sb.push_back(8'd6);
      for (int i = 0; i < 3; i++) applyStimulus(8'd6);
      applyStimulus(8'd6, 2, 6, 1'b1);
      checkOutput("t4_level_pushpop", 32'(fifo_level), 4);
      checkOutput("t4_overflow_kept", 32'(overflow),   1);
      checkOutput("t4_head_after",    32'(avg_data),   2);
      drain(4);
      checkOutput("t4_drained", 32'(fifo_level), 0);

      // Enable drop mid-block keeps FIFO, discards partial block
      block4(8'd20);
      applyStimulus(8'd100); applyStimulus(8'd100);
      tick();
      enable = 1'b0;
      repeat (3) tick();
      checkOutput("t5_cnt_disabled",  32'(sample_cnt), 0);
      checkOutput("t5_fifo_retained", 32'(fifo_level), 1);
      enable = 1'b1;
      block4(8'd8);
      checkOutput("t5_level", 32'(fifo_level), 2);
      drain(2);

      // Asynchronous reset mid-operation
      block4(8'd40, 1'b0);
      block4(8'd60, 1'b0);
      applyStimulus(8'd7); applyStimulus(8'd7); applyStimulus(8'd7);
      checkOutput("t6_pre_level", 32'(fifo_level), 2);
      checkOutput("t6_pre_cnt",   32'(sample_cnt), 3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("t6_avg_data",   32'(avg_data),   0);
      checkOutput("t6_avg_valid",  32'(avg_valid),  0);
      checkOutput("t6_fifo_level", 32'(fifo_level), 0);
      checkOutput("t6_overflow",   32'(overflow),   0);
      checkOutput("t6_sample_cnt", 32'(sample_cnt), 0);
      tick();
      rst = 1'b0;
      block4(8'd9);
      checkOutput("t6_fresh_level", 32'(fifo_level), 1);
      checkOutput("t6_fresh_data",  32'(avg_data),   9);
      drain(1);
      repeat (2) tick();
      checkOutput("sb_empty", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
